// File: rtl/seq_add_accumulator.sv
// seq_add_accumulator: sums FRAME_LEN 5-bit adder results ({carry, sum}) per frame
// and presents the frame total with a sticky overflow flag on a valid/ready output.
// Build option: define ACC_SAT_EN to clamp the total at 2^ACC_W-1 on overflow;
// without it the total wraps modulo 2^ACC_W. The overflow flag is the same in both builds.
module seq_add_accumulator #(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       sum_in,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam int unsigned CNT_W = 8;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] sample;
  logic [ACC_W:0]   sum_full;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_add;
  logic [CNT_W-1:0] count_inc;
  logic             accept;
  logic             last;

  // Datapath helpers: zero-extended sample, carry-aware add, frame-complete detect
  assign sample    = ACC_W'({carry_in, sum_in});
  assign sum_full  = (ACC_W+1)'(acc_out) + (ACC_W+1)'(sample);
  assign add_ovf   = sum_full[ACC_W];
  assign accept    = in_valid & in_ready;
  assign count_inc = count + CNT_W'(1);
  assign last      = (count_inc == CNT_W'(FRAME_LEN));

`ifdef ACC_SAT_EN
  assign acc_add = add_ovf ? ACC_MAX : sum_full[ACC_W-1:0];
`else
  assign acc_add = sum_full[ACC_W-1:0];
`endif

  // Frame FSM with registered handshake outputs and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_out   <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (accept) begin
            acc_out  <= sample;
            count    <= CNT_W'(1);
            overflow <= 1'b0;
            if (CNT_W'(FRAME_LEN) == CNT_W'(1)) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (accept) begin
            acc_out  <= acc_add;
            count    <= count_inc;
            overflow <= overflow | add_ovf;
            if (last) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          // Frame held until the consumer takes it; inputs are refused meanwhile
          if (out_ready) begin
            state     <= IDLE;
            acc_out   <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          acc_out   <= '0;
          count     <= '0;
          overflow  <= 1'b0;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_accumulator.sv
// Bench for seq_add_accumulator: three instances (4/8, 4/6, 1/8 frame/width),
// scoreboard of frame totals from a bench-side model, ACC_SAT_EN-aware.
module tb_seq_add_accumulator;

  logic       clk;
  logic       rst_n;
  logic [4:0] smp [3];
  logic [2:0] iv, ir, ov, ordy, ovf;
  logic [7:0] acc0, acc2;
  logic [5:0] acc1;

  typedef struct {
    int k;
    int acc;
    bit ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  seq_add_accumulator #(.FRAME_LEN(4), .ACC_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sum_in(smp[0][3:0]), .carry_in(smp[0][4]),
    .in_valid(iv[0]), .in_ready(ir[0]), .acc_out(acc0), .out_valid(ov[0]),
    .out_ready(ordy[0]), .overflow(ovf[0]));

  seq_add_accumulator #(.FRAME_LEN(4), .ACC_W(6)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sum_in(smp[1][3:0]), .carry_in(smp[1][4]),
    .in_valid(iv[1]), .in_ready(ir[1]), .acc_out(acc1), .out_valid(ov[1]),
    .out_ready(ordy[1]), .overflow(ovf[1]));

  seq_add_accumulator #(.FRAME_LEN(1), .ACC_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sum_in(smp[2][3:0]), .carry_in(smp[2][4]),
    .in_valid(iv[2]), .in_ready(ir[2]), .acc_out(acc2), .out_valid(ov[2]),
    .out_ready(ordy[2]), .overflow(ovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int get_acc(input int k);
    if (k == 0) return int'(acc0);
    if (k == 1) return int'(acc1);
    return int'(acc2);
  endfunction

  function automatic int aw_of(input int k);
    return (k == 1) ? 6 : 8;
  endfunction

  // One accumulate step of the reference model
  function automatic void step(input int aw, input int tot_i, input int s,
                               output int tot_o, output bit of);
    int mx;
    int t;
    mx = (1 << aw) - 1;
    t  = tot_i + s;
    of = 1'b0;
    if (t > mx) begin
      of = 1'b1;
`ifdef ACC_SAT_EN
      t = mx;
`else
      t = t & mx;
`endif
    end
    tot_o = t;
  endfunction

  function automatic void mk4(output int q[$], input int a, input int b, input int c, input int d);
    q.delete();
    q.push_back(a); q.push_back(b); q.push_back(c); q.push_back(d);
  endfunction

  // Offer one sample until accepted (bounded); returns on the negedge after the accept edge
  task automatic drive_sample(input int k, input int s);
    int w;
    w = 0;
    smp[k] = 5'(s);
    iv[k]  = 1'b1;
    while (!ir[k] && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ir[k]) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout inst=%0d: in_ready=%b required 1", k, ir[k]);
    end
    @(negedge clk);
    iv[k] = 1'b0;
  endtask

  task automatic send_frame(input int k, input int s[$], input int gap);
    int   run;
    int   nrun;
    bit   of;
    bit   sof;
    int   tot;
    bit   tof;
    exp_t e;
    run = 0; of = 1'b0; tot = 0; tof = 1'b0;
    foreach (s[i]) begin
      step(aw_of(k), tot, s[i], tot, sof);
      tof = tof | sof;
    end
    e.k = k; e.acc = tot; e.ovf = tof;
    sb.push_back(e);
    foreach (s[i]) begin
      drive_sample(k, s[i]);
      step(aw_of(k), run, s[i], nrun, sof);
      run = nrun;
      of  = of | sof;
      if (i < s.size() - 1) begin
        n_cmp++;
        if (get_acc(k) !== run || ov[k] !== 1'b0 || ovf[k] !== of) begin
          n_bad++;
          $display("FAIL running_total inst=%0d idx=%0d: acc=%0d ov=%b ovf=%b required acc=%0d ov=0 ovf=%b",
                   k, i, get_acc(k), ov[k], ovf[k], run, of);
        end
        repeat (gap) begin
          @(negedge clk);
          n_cmp++;
          if (get_acc(k) !== run || ov[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL gap_hold inst=%0d: acc=%0d ov=%b required acc=%0d ov=0", k, get_acc(k), ov[k], run);
          end
        end
      end else begin
        n_cmp++;
        if (ov[k] !== 1'b1) begin
          n_bad++;
          $display("FAIL out_valid_latency inst=%0d: out_valid=%b required 1", k, ov[k]);
        end
      end
    end
  endtask

  // Wait for a frame, compare against scoreboard, hold for 'hold' cycles, then release
  task automatic expect_out(input int k, input int hold);
    int   w;
    int   held;
    exp_t e;
    w = 0;
    while (!ov[k] && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (!ov[k]) begin
      n_bad++;
      $display("FAIL out_timeout inst=%0d: out_valid=%b required 1", k, ov[k]);
    end
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty inst=%0d: size=0 required >0", k);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (e.k !== k || get_acc(k) !== e.acc) begin
        n_bad++;
        $display("FAIL frame_total inst=%0d: acc=%0d required %0d (exp inst %0d)", k, get_acc(k), e.acc, e.k);
      end
      n_cmp++;
      if (ovf[k] !== e.ovf) begin
        n_bad++;
        $display("FAIL frame_overflow inst=%0d: overflow=%b required %b", k, ovf[k], e.ovf);
      end
    end
    held   = get_acc(k);
    smp[k] = 5'd31;
    iv[k]  = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      n_cmp++;
      if (ir[k] !== 1'b0 || ov[k] !== 1'b1 || get_acc(k) !== held) begin
        n_bad++;
        $display("FAIL done_hold inst=%0d: in_ready=%b out_valid=%b acc=%0d required 0 1 %0d",
                 k, ir[k], ov[k], get_acc(k), held);
      end
    end
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    iv[k]   = 1'b0;
    n_cmp++;
    if (ov[k] !== 1'b0 || get_acc(k) !== 0 || ovf[k] !== 1'b0 || ir[k] !== 1'b1) begin
      n_bad++;
      $display("FAIL release inst=%0d: out_valid=%b acc=%0d overflow=%b in_ready=%b required 0 0 0 1",
               k, ov[k], get_acc(k), ovf[k], ir[k]);
    end
  endtask

  // Async reset pulse: outputs forced to zero at once, in_ready returns one edge after release
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (get_acc(k) !== 0 || ov[k] !== 1'b0 || ovf[k] !== 1'b0 || ir[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_outputs inst=%0d: acc=%0d out_valid=%b overflow=%b in_ready=%b required all 0",
                 k, get_acc(k), ov[k], ovf[k], ir[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (ir !== 3'b000) begin
      n_bad++;
      $display("FAIL ready_before_edge: in_ready=%b required 000", ir);
    end
    @(negedge clk);
    n_cmp++;
    if (ir !== 3'b111 || ov !== 3'b000) begin
      n_bad++;
      $display("FAIL ready_after_edge: in_ready=%b out_valid=%b required 111 000", ir, ov);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (ir !== 3'b000 || ov !== 3'b000 || ovf !== 3'b000 || acc0 !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_initial: in_ready=%b out_valid=%b overflow=%b acc0=%0d required 0s", ir, ov, ovf, acc0);
    end
    do_reset();
  endtask

  task automatic test_basic();
    int q[$];
    mk4(q, 21, 3, 0, 31);
    send_frame(0, q, 0);
    expect_out(0, 0);
  endtask

  task automatic test_done_hold();
    int q[$];
    mk4(q, 10, 20, 30, 31);
    send_frame(0, q, 0);
    expect_out(0, 5);
    mk4(q, 1, 2, 3, 4);
    send_frame(0, q, 0);
    expect_out(0, 1);
  endtask

  task automatic test_gapped();
    int q[$];
    mk4(q, 21, 3, 0, 31);
    send_frame(0, q, 2);
    expect_out(0, 0);
  endtask

  task automatic test_overflow();
    int q[$];
    mk4(q, 31, 31, 31, 31);
    send_frame(1, q, 0);
    expect_out(1, 2);
  endtask

  task automatic test_reset_midframe();
    int q[$];
    drive_sample(0, 7);
    drive_sample(0, 9);
    do_reset();
    mk4(q, 2, 2, 2, 2);
    send_frame(0, q, 0);
    expect_out(0, 0);
  endtask

  task automatic test_reset_in_done();
    int q[$];
    q.delete();
    q.push_back(5);
    send_frame(2, q, 0);
    do_reset();
    void'(sb.pop_back());
  endtask

  task automatic test_frame_len1();
    int q[$];
    q.delete();
    q.push_back(17);
    send_frame(2, q, 0);
    expect_out(2, 1);
  endtask

  task automatic test_back_to_back();
    int q[$];
    for (int f = 0; f < 6; f++) begin
      mk4(q, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      send_frame(1, q, 0);
      expect_out(1, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iv    = 3'b000;
    ordy  = 3'b000;
    for (int k = 0; k < 3; k++) smp[k] = 5'd0;
    test_reset();
    test_basic();
    test_done_hold();
    test_gapped();
    test_overflow();
    test_reset_midframe();
    test_reset_in_done();
    test_frame_len1();
    test_back_to_back();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: size=%0d required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
